// File: rtl/hit_storage_engine.sv
// hit_storage_engine
// Stores (SSID, hitInfo) pairs in three memories and streams them back on request:
//   HNM - hit-new bitmap, one bit per SSID, packed HNM_COLS bits per row
//   HCM - per-SSID {HIM row address, hit count}
//   HIM - packed hit-info rows, MAX_HITS slots each, slot 0 in the low bits
// Only HNM is swept to zero on a clear; HCM and HIM entries are trusted only
// when the SSID's HNM bit is set.
// Ports:
//   clock, resetN                 rising-edge clock, asynchronous active-low reset
//   clearMemory                   request a clear sweep (pulse or level)
//   inValid/inReady/inSSID/inHitInfo             hit input handshake
//   queryValid/queryReady/querySSID              readout request handshake
//   outValid/outReady/outHitInfo/outCount/outLast/outEmpty   readout beats
//   busy, himFull, hitDropped, dropCount, storedSSIDs        status
module hit_storage_engine #(
   parameter int SSID_BITS     = 12,
   parameter int HIT_INFO_BITS = 8,
   parameter int HNM_COLS      = 32,
   parameter int MAX_HITS      = 4,
   parameter int HIM_DEPTH     = 256,
   parameter int DROP_CNT_BITS = 16,
   localparam int CNT_BITS     = $clog2(MAX_HITS + 1),
   localparam int ADDR_BITS    = $clog2(HIM_DEPTH),
   localparam int NA_BITS      = ADDR_BITS + 1
) (
   input  logic                     clock,
   input  logic                     resetN,
   input  logic                     clearMemory,
   input  logic                     inValid,
   output logic                     inReady,
   input  logic [SSID_BITS-1:0]     inSSID,
   input  logic [HIT_INFO_BITS-1:0] inHitInfo,
   input  logic                     queryValid,
   output logic                     queryReady,
   input  logic [SSID_BITS-1:0]     querySSID,
   output logic                     outValid,
   input  logic                     outReady,
   output logic [HIT_INFO_BITS-1:0] outHitInfo,
   output logic [CNT_BITS-1:0]      outCount,
   output logic                     outLast,
   output logic                     outEmpty,
   output logic                     busy,
   output logic                     himFull,
   output logic                     hitDropped,
   output logic [DROP_CNT_BITS-1:0] dropCount,
   output logic [NA_BITS-1:0]       storedSSIDs
);

   localparam int SSID_SPACE = 2 ** SSID_BITS;
   localparam int HNM_ROWS   = SSID_SPACE / HNM_COLS;
   localparam int COL_BITS   = $clog2(HNM_COLS);
   localparam int ROW_BITS   = SSID_BITS - COL_BITS;
   localparam int HCM_W      = ADDR_BITS + CNT_BITS;
   localparam int HIM_W      = MAX_HITS * HIT_INFO_BITS;
   localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(HNM_ROWS - 1);
   localparam logic [NA_BITS-1:0]  DEPTH_V  = NA_BITS'(HIM_DEPTH);
   localparam logic [CNT_BITS-1:0] MAX_V    = CNT_BITS'(MAX_HITS);

   typedef enum logic [2:0] {
      S_CLEAR, S_IDLE, S_WR_LOOKUP, S_WR_COMMIT, S_RD_LOOKUP, S_RD_HIM, S_RD_STREAM
   } state_t;

   state_t state, state_nx;

   logic [ROW_BITS-1:0]      row_ptr;
   logic                     clear_pend;
   logic [NA_BITS-1:0]       next_addr;
   logic                     him_full;
   logic                     hit_dropped;
   logic [DROP_CNT_BITS-1:0] drop_cnt;
   logic [CNT_BITS-1:0]      beat_idx;

   logic [SSID_BITS-1:0]     req_ssid;
   logic [HIT_INFO_BITS-1:0] req_info;

   logic [HNM_COLS-1:0] hnm_mem [HNM_ROWS];
   logic [HCM_W-1:0]    hcm_mem [SSID_SPACE];
   logic [HIM_W-1:0]    him_mem [HIM_DEPTH];
   logic [HNM_COLS-1:0] hnm_q;
   logic [HCM_W-1:0]    hcm_q;
   logic [HIM_W-1:0]    him_q;

   logic                     idle, take_clear, acc_q, acc_w;
   logic                     is_commit, hit_known, new_ok, old_ok, store, drop;
   logic [SSID_BITS-1:0]     rd_ssid;
   logic [ADDR_BITS-1:0]     hcm_addr;
   logic [CNT_BITS-1:0]      hcm_cnt;
   logic                     hnm_we;
   logic [ROW_BITS-1:0]      hnm_wa;
   logic [HNM_COLS-1:0]      hnm_wd;
   logic [HCM_W-1:0]         hcm_wd;
   logic [ADDR_BITS-1:0]     him_wa;
   logic [HIM_W-1:0]         him_wd;
   logic [HIT_INFO_BITS-1:0] slot_info;
   logic                     beat_last;

   assign idle       = (state == S_IDLE);
   assign take_clear = clearMemory | clear_pend;
   // Query has priority over a hit, so inReady also yields to a pending query.
   assign queryReady = idle & ~take_clear;
   assign inReady    = queryReady & ~queryValid;
   assign acc_q      = queryReady & queryValid;
   assign acc_w      = inReady & inValid;

   // Reads run every cycle. In IDLE the address comes straight from the hit
   // port so the lookup data is ready one cycle after accept; otherwise the
   // held request SSID keeps the read data current.
   assign rd_ssid   = idle ? inSSID : req_ssid;
   assign hcm_addr  = hcm_q[HCM_W-1:CNT_BITS];
   assign hcm_cnt   = hcm_q[CNT_BITS-1:0];
   assign hit_known = hnm_q[req_ssid[COL_BITS-1:0]];

   assign is_commit = (state == S_WR_COMMIT);
   assign new_ok    = ~hit_known & (next_addr < DEPTH_V);
   assign old_ok    = hit_known & (hcm_cnt < MAX_V);
   assign store     = is_commit & (new_ok | old_ok);
   assign drop      = is_commit & ~(new_ok | old_ok);

   always_comb begin
      hnm_we = (state == S_CLEAR) | (is_commit & new_ok);
      hnm_wa = (state == S_CLEAR) ? row_ptr : req_ssid[SSID_BITS-1:COL_BITS];
      hnm_wd = (state == S_CLEAR) ? '0
             : (hnm_q | (HNM_COLS'(1) << req_ssid[COL_BITS-1:0]));
      hcm_wd = new_ok ? {next_addr[ADDR_BITS-1:0], CNT_BITS'(1)}
                      : {hcm_addr, hcm_cnt + CNT_BITS'(1)};
      him_wa = new_ok ? next_addr[ADDR_BITS-1:0] : hcm_addr;
      // Appending rewrites the whole row: earlier slots come from the HIM read
      // issued during the lookup cycle.
      him_wd = new_ok ? HIM_W'(req_info) : him_q;
      if (!new_ok) begin
         for (int k = 0; k < MAX_HITS; k++) begin
            if (hcm_cnt == CNT_BITS'(k)) him_wd[k*HIT_INFO_BITS +: HIT_INFO_BITS] = req_info;
         end
      end
   end

   always_comb begin
      slot_info = '0;
      for (int k = 0; k < MAX_HITS; k++) begin
         if (beat_idx == CNT_BITS'(k)) slot_info = him_q[k*HIT_INFO_BITS +: HIT_INFO_BITS];
      end
   end

   assign beat_last = ~hit_known | (beat_idx == hcm_cnt - CNT_BITS'(1));

   always_comb begin
      state_nx = state;
      case (state)
         S_CLEAR:     if (row_ptr == ROW_LAST) state_nx = S_IDLE;
         S_IDLE: begin
            if (take_clear) state_nx = S_CLEAR;
            else if (acc_q) state_nx = S_RD_LOOKUP;
            else if (acc_w) state_nx = S_WR_LOOKUP;
         end
         S_WR_LOOKUP: state_nx = S_WR_COMMIT;
         S_WR_COMMIT: state_nx = S_IDLE;
         S_RD_LOOKUP: state_nx = S_RD_HIM;
         S_RD_HIM:    state_nx = S_RD_STREAM;
         S_RD_STREAM: if (outReady && beat_last) state_nx = S_IDLE;
         default:     state_nx = S_CLEAR;
      endcase
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state       <= S_CLEAR;
         row_ptr     <= '0;
         clear_pend  <= 1'b0;
         next_addr   <= '0;
         him_full    <= 1'b0;
         hit_dropped <= 1'b0;
         drop_cnt    <= '0;
         beat_idx    <= '0;
      end else begin
         state       <= state_nx;
         hit_dropped <= drop;
         if (state == S_CLEAR) begin
            row_ptr   <= row_ptr + ROW_BITS'(1);
            next_addr <= '0;
            him_full  <= 1'b0;
         end else begin
            row_ptr <= '0;
         end
         // A request arriving during a sweep is already covered by that sweep.
         if (idle && take_clear) clear_pend <= 1'b0;
         else if (clearMemory && !idle && state != S_CLEAR) clear_pend <= 1'b1;
         if (is_commit && new_ok) next_addr <= next_addr + NA_BITS'(1);
         if (drop) begin
            if (drop_cnt != {DROP_CNT_BITS{1'b1}}) drop_cnt <= drop_cnt + DROP_CNT_BITS'(1);
            if (!hit_known) him_full <= 1'b1;
         end
         if (state == S_RD_HIM) beat_idx <= '0;
         else if (state == S_RD_STREAM && outReady) beat_idx <= beat_idx + CNT_BITS'(1);
      end
   end

   always_ff @(posedge clock) begin
      hnm_q <= hnm_mem[rd_ssid[SSID_BITS-1:COL_BITS]];
      hcm_q <= hcm_mem[rd_ssid];
      him_q <= him_mem[hcm_addr];
      if (hnm_we) hnm_mem[hnm_wa] <= hnm_wd;
      if (store) begin
         hcm_mem[req_ssid] <= hcm_wd;
         him_mem[him_wa]   <= him_wd;
      end
      if (acc_q) begin
         req_ssid <= querySSID;
      end else if (acc_w) begin
         req_ssid <= inSSID;
         req_info <= inHitInfo;
      end
   end

   assign outValid    = (state == S_RD_STREAM);
   assign outEmpty    = outValid & ~hit_known;
   assign outLast     = outValid & beat_last;
   assign outCount    = (outValid & hit_known) ? hcm_cnt : '0;
   assign outHitInfo  = (outValid & hit_known) ? slot_info : '0;
   assign busy        = ~idle;
   assign himFull     = him_full;
   assign hitDropped  = hit_dropped;
   assign dropCount   = drop_cnt;
   assign storedSSIDs = next_addr;

endmodule

// File: tb/tb_hit_storage_engine.sv
// Self-checking bench for hit_storage_engine (SSID_BITS=8, HNM_COLS=16,
// MAX_HITS=4, HIM_DEPTH=4). A queue-based reference model predicts every
// readout beat; a monitor compares beats as the DUT presents them.
module tb_hit_storage_engine;

   localparam int SB = 8;
   localparam int IB = 8;
   localparam int MH = 4;
   localparam int HD = 4;

   logic          clock = 1'b0;
   logic          resetN, clearMemory, inValid, queryValid, outReady;
   logic [SB-1:0] inSSID, querySSID;
   logic [IB-1:0] inHitInfo;
   logic          inReady, queryReady, outValid, outLast, outEmpty;
   logic          busy, himFull, hitDropped;
   logic [IB-1:0] outHitInfo;
   logic [2:0]    outCount;
   logic [15:0]   dropCount;
   logic [2:0]    storedSSIDs;

   hit_storage_engine #(
      .SSID_BITS(SB), .HIT_INFO_BITS(IB), .HNM_COLS(16),
      .MAX_HITS(MH), .HIM_DEPTH(HD), .DROP_CNT_BITS(16)
   ) dut (
      .clock(clock), .resetN(resetN), .clearMemory(clearMemory),
      .inValid(inValid), .inReady(inReady), .inSSID(inSSID), .inHitInfo(inHitInfo),
      .queryValid(queryValid), .queryReady(queryReady), .querySSID(querySSID),
      .outValid(outValid), .outReady(outReady), .outHitInfo(outHitInfo),
      .outCount(outCount), .outLast(outLast), .outEmpty(outEmpty),
      .busy(busy), .himFull(himFull), .hitDropped(hitDropped),
      .dropCount(dropCount), .storedSSIDs(storedSSIDs)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [IB-1:0] info;
      logic [2:0]    cnt;
      logic          last;
      logic          empty;
   } beat_t;

   beat_t exp_q[$];
   int    n_checks = 0;
   int    n_pass = 0;
   int    drop_pulses = 0;
   int    beats_seen = 0;

   // Reference model: what the store should hold, by SSID.
   bit            known [256];
   int            mcnt  [256];
   logic [IB-1:0] mhit  [256][MH];
   int            m_stored = 0;
   bit            m_full = 0;
   int            m_drops = 0;
   bit            rand_ready = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic model_write(input int s, input logic [IB-1:0] info);
      if (!known[s]) begin
         if (m_stored < HD) begin
            known[s] = 1; mhit[s][0] = info; mcnt[s] = 1; m_stored++;
         end else begin
            m_full = 1; m_drops++;
         end
      end else if (mcnt[s] < MH) begin
         mhit[s][mcnt[s]] = info; mcnt[s]++;
      end else begin
         m_drops++;
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 256; i++) known[i] = 0;
      m_stored = 0; m_full = 0;
   endtask

   task automatic push_expected(input int s);
      beat_t b;
      if (!known[s]) begin
         b.info = '0; b.cnt = '0; b.last = 1'b1; b.empty = 1'b1;
         exp_q.push_back(b);
      end else begin
         for (int k = 0; k < mcnt[s]; k++) begin
            b.info = mhit[s][k]; b.cnt = 3'(mcnt[s]);
            b.last = (k == mcnt[s] - 1); b.empty = 1'b0;
            exp_q.push_back(b);
         end
      end
   endtask

   // Monitor: every presented beat is compared with the head of the queue;
   // the head is popped only when the beat is accepted.
   always @(negedge clock) begin
      beat_t e;
      if (hitDropped) drop_pulses++;
      if (outValid) begin
         if (exp_q.size() == 0) begin
            chk("beat_expected", 32'(outValid), 32'd0);
         end else begin
            e = exp_q[0];
            chk("outHitInfo", 32'(outHitInfo), 32'(e.info));
            chk("outCount", 32'(outCount), 32'(e.cnt));
            chk("outLast", 32'(outLast), 32'(e.last));
            chk("outEmpty", 32'(outEmpty), 32'(e.empty));
            if (outReady) begin
               void'(exp_q.pop_front());
               beats_seen++;
            end
         end
      end
   end

   task automatic wait_ready();
      bit ok = 0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clock);
         if (queryReady) begin ok = 1; break; end
      end
      chk("ready_wait", 32'(ok), 32'd1);
      @(posedge clock); #1;
   endtask

   task automatic do_write(input logic [SB-1:0] s, input logic [IB-1:0] info);
      bit ok = 0;
      inValid = 1'b1; inSSID = s; inHitInfo = info;
      for (int n = 0; n < 100; n++) begin
         @(negedge clock);
         if (inReady) begin ok = 1; break; end
      end
      @(posedge clock); #1;
      inValid = 1'b0;
      chk("wr_accept", 32'(ok), 32'd1);
      if (ok) model_write(int'(s), info);
   endtask

   task automatic do_query(input logic [SB-1:0] s, input int stall);
      bit ok = 0;
      bit done = 0;
      int lat = 0;
      queryValid = 1'b1; querySSID = s;
      for (int n = 0; n < 100; n++) begin
         @(negedge clock);
         if (queryReady) begin ok = 1; break; end
      end
      @(posedge clock); #1;
      queryValid = 1'b0;
      chk("rd_accept", 32'(ok), 32'd1);
      if (ok) push_expected(int'(s));
      for (int n = 1; n <= 20; n++) begin
         @(negedge clock);
         if (outValid) begin lat = n; break; end
      end
      chk("query_latency", 32'(lat), 32'd3);
      if (stall > 0) begin
         @(posedge clock); #1;
         outReady = 1'b0;
         repeat (stall) @(posedge clock);
         #1;
         outReady = 1'b1;
      end
      for (int n = 0; n < 200; n++) begin
         @(negedge clock);
         if (exp_q.size() == 0 && !busy) begin done = 1; break; end
      end
      chk("query_drain", 32'(done), 32'd1);
      @(posedge clock); #1;
   endtask

   task automatic do_clear();
      clearMemory = 1'b1;
      @(posedge clock); #1;
      clearMemory = 1'b0;
      model_clear();
      wait_ready();
   endtask

   task automatic check_status(input string tag);
      chk({tag, "_storedSSIDs"}, 32'(storedSSIDs), 32'(m_stored));
      chk({tag, "_himFull"}, 32'(himFull), 32'(m_full));
      chk({tag, "_dropCount"}, 32'(dropCount), 32'(m_drops));
      chk({tag, "_dropPulses"}, 32'(drop_pulses), 32'(m_drops));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int p0, b0;
      logic [SB-1:0] pool [8];
      resetN = 1'b0; clearMemory = 1'b0; inValid = 1'b0; queryValid = 1'b0;
      outReady = 1'b1; inSSID = '0; inHitInfo = '0; querySSID = '0;
      for (int i = 0; i < 256; i++) begin known[i] = 0; mcnt[i] = 0; end

      // Reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_inReady", 32'(inReady), 32'd0);
      chk("rst_queryReady", 32'(queryReady), 32'd0);
      chk("rst_outValid", 32'(outValid), 32'd0);
      chk("rst_hitDropped", 32'(hitDropped), 32'd0);
      chk("rst_outLast", 32'(outLast), 32'd0);
      check_status("rst");
      @(posedge clock); #1;
      resetN = 1'b1;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (busy) n++; else break;
      end
      chk("clear_cycles", 32'(n), 32'd16);
      chk("inReady_after_clear", 32'(inReady), 32'd1);
      @(posedge clock); #1;

      // 1: empty SSID
      do_query(8'h35, 0);

      // 2: three hits on one SSID
      do_write(8'h35, 8'hA1); do_write(8'h35, 8'hA2); do_write(8'h35, 8'hA3);
      do_query(8'h35, 0);
      check_status("t2");

      // 3: per-SSID overflow
      for (int i = 1; i <= 6; i++) do_write(8'h10, 8'(i));
      wait_ready();
      check_status("t3");
      do_query(8'h10, 0);

      // 4: HIM exhaustion and clear
      do_clear();
      do_write(8'h00, 8'h5C); do_write(8'h11, 8'h6D);
      do_write(8'h22, 8'h7E); do_write(8'h33, 8'h8F);
      wait_ready();
      check_status("t4a");
      do_write(8'h44, 8'h90);
      wait_ready();
      check_status("t4b");
      do_query(8'h33, 0);
      do_query(8'h44, 0);
      do_clear();
      check_status("t4c");
      do_query(8'h11, 0);

      // 5: backpressure mid-stream
      do_write(8'h5A, 8'($urandom)); do_write(8'h5A, 8'($urandom)); do_write(8'h5A, 8'($urandom));
      b0 = beats_seen;
      do_query(8'h5A, 5);
      chk("t5_beats", 32'(beats_seen - b0), 32'd3);

      // 6: clear requested during the commit of a write
      do_write(8'h20, 8'h3C);
      @(posedge clock); #1;
      clearMemory = 1'b1;
      @(posedge clock); #1;
      clearMemory = 1'b0;
      @(negedge clock);
      chk("t6_idle_busy", 32'(busy), 32'd0);
      chk("t6_idle_queryReady", 32'(queryReady), 32'd0);
      chk("t6_idle_inReady", 32'(inReady), 32'd0);
      chk("t6_committed", 32'(storedSSIDs), 32'(m_stored));
      @(negedge clock);
      chk("t6_sweep_busy", 32'(busy), 32'd1);
      model_clear();
      wait_ready();
      check_status("t6");
      do_query(8'h20, 0);

      // Randomised traffic with random output backpressure
      do_clear();
      for (int i = 0; i < 8; i++) pool[i] = 8'($urandom_range(0, 255));
      rand_ready = 1;
      fork
         begin
            while (rand_ready) begin
               @(posedge clock); #1;
               outReady = 1'($urandom_range(0, 1));
            end
            outReady = 1'b1;
         end
      join_none
      p0 = drop_pulses;
      for (int i = 0; i < 40; i++) begin
         do_write(pool[$urandom_range(0, 7)], 8'($urandom));
         if ($urandom_range(0, 3) == 0) do_query(pool[$urandom_range(0, 7)], 0);
      end
      for (int i = 0; i < 8; i++) do_query(pool[i], 0);
      rand_ready = 0;
      repeat (3) @(posedge clock);
      #1;
      check_status("rand");
      chk("rand_pulses_seen", 32'(drop_pulses - p0 > 0 || m_drops == 0), 32'd1);

      // Reset asserted while a beat is stalled
      do_write(8'h50, 8'h77); do_write(8'h50, 8'h78);
      wait_ready();
      outReady = 1'b0;
      queryValid = 1'b1; querySSID = 8'h50;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (queryReady) break;
      end
      @(posedge clock); #1;
      queryValid = 1'b0;
      push_expected(8'h50);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (outValid) break;
      end
      chk("mid_outValid", 32'(outValid), 32'd1);
      #1;
      resetN = 1'b0;
      #1;
      chk("reset_drops_outValid", 32'(outValid), 32'd0);
      exp_q.delete();
      model_clear();
      m_drops = 0; drop_pulses = 0;
      outReady = 1'b1;
      @(posedge clock); #1;
      resetN = 1'b1;
      wait_ready();
      check_status("post_rst");
      do_query(8'h50, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
